hart_run_ctrl: RTL and testbench
================================

// Module: hart_run_ctrl
// PURPOSE
//  Synthesizable run controller that replaces hand-toggled clock/reset stimulus around HART instances.
//  Sequences reset for NUM_HARTS harts: hold, then staggered release.
//  Watches per-hart halt indications and enforces a cycle-budget timeout.
//  Reports done/timeout status and a run-cycle count.
//  Sits between the top-level clock/reset and the hart array; usable in benches and on FPGA.
// PARAMETERS
//  NUM_HARTS       1     number of controlled harts (1..32)
//  RESET_CYCLES    4     cycles all hart resets are held after start (>=1)
//  STAGGER_CYCLES  0     gap between consecutive hart releases; 0 = release all together
//  TIMEOUT_CYCLES  1000  run-cycle budget before timeout; 0 = timeout disabled
//  CNT_W           32    width of cycle counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset        in   1          asynchronous, active-low controller reset
//  start        in   1          1-cycle pulse: begin (or restart) a run
//  abort        in   1          1-cycle pulse: stop run, return to IDLE
//  hart_halted  in   NUM_HARTS  per-hart level: hart reached halt (ecall/ebreak)
//  hart_reset   out  NUM_HARTS  per-hart reset to HART instances, active-high
//  running      out  1          1 while in RELEASE or RUN
//  done         out  1          sticky: all harts halted; cleared by start/abort
//  timeout      out  1          sticky: budget exhausted; cleared by start/abort
//  halted_mask  out  NUM_HARTS  sticky per-hart halt record for the current run
//  cycle_count  out  CNT_W      cycles spent in RELEASE+RUN, saturating
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, hart_reset=all 1, running=0, done=0, timeout=0,
//   halted_mask=0, cycle_count=0, internal counters=0.
//  States: IDLE, HOLD, RELEASE, RUN, DONE, TMO. All outputs registered.
//  IDLE:    hart_reset all 1. start -> HOLD next cycle; clears done/timeout/halted_mask/cycle_count.
//  HOLD:    hart_reset all 1 for exactly RESET_CYCLES cycles, then -> RELEASE.
//           If STAGGER_CYCLES==0 -> RUN directly.
//  RELEASE: hart_reset[i] drops at cycle i*STAGGER_CYCLES after RELEASE entry (hart 0 immediately).
//           After last hart drops -> RUN.
//           With STAGGER_CYCLES==0 all bits drop together on the first cycle after HOLD.
//  RUN:     halted_mask[i] |= hart_halted[i] & ~hart_reset[i]; halt of a hart still in reset is ignored.
//           Same sampling also applies in RELEASE.
//  Halt:    when halted_mask (incl. this cycle's update) is all ones -> DONE.
//  Timeout: when cycle_count reaches TIMEOUT_CYCLES-1 and not all halted -> TMO.
//           Same-cycle all-halted and budget expiry: DONE wins, timeout stays 0.
//  DONE:    done=1, hart_reset all 1 (freeze harts), running=0, cycle_count frozen.
//  TMO:     timeout=1, hart_reset all 1, running=0, cycle_count frozen.
//  start in DONE/TMO/HOLD/RELEASE/RUN: restart -> HOLD, flags and counters cleared.
//  abort in any state except IDLE -> IDLE next cycle, hart_reset all 1, flags cleared.
//  start and abort in the same cycle: abort wins.
//  cycle_count increments once per cycle in RELEASE/RUN and saturates at 2^CNT_W-1.
//  Latency: start at edge t -> hart_reset[0] low at edge t+1+RESET_CYCLES.
//  reset asserted mid-run: immediate async return to reset values; hart_reset goes 1 without waiting for clk.
// STRUCTURE
//  Package hart_ctrl_pkg: state enum typedef (hart_ctrl_state_t), MAX_HARTS=32 constant.
//  One sub-module, sat_counter #(W): enable, clear, saturating count.
//  sat_counter is used for the cycle_count and HOLD/stagger counters.
//  FSM, release mask and halt mask live in hart_run_ctrl.
// TESTING
//  T1: reset low 3 cycles -> hart_reset=1, done=0, timeout=0, cycle_count=0; async drop mid-cycle is observed without clk.
//  T2: NUM_HARTS=1, RESET_CYCLES=4, start at cycle 10 -> hart_reset low at cycle 15.
//      hart_halted at cycle 40 -> done=1 at 41, hart_reset=1, cycle_count=26.
//  T3: NUM_HARTS=4, STAGGER_CYCLES=3 -> releases 3 cycles apart (offsets 0,3,6,9).
//      hart 3 asserting hart_halted while still in reset is not recorded.
//  T4: TIMEOUT_CYCLES=20, harts never halt -> timeout=1 after 20 run cycles, cycle_count=20, done=0.
//  T5: last hart halts in the same cycle the budget expires -> done=1, timeout=0.
//  T6: abort during RUN -> IDLE, all flags 0, hart_reset=1.
//      start+abort in the same cycle -> IDLE.
//      start during DONE -> new HOLD, halted_mask=0.

Source files
------------

// File: rtl/hart_run_ctrl_pkg.sv
// Shared definitions for the hart run controller.
//   hart_ctrl_state_t : controller FSM states
//   MAX_HARTS         : largest supported hart count
package hart_ctrl_pkg;

    localparam int MAX_HARTS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TMO     = 3'd5
    } hart_ctrl_state_t;

endpackage

// File: rtl/hart_run_ctrl_if.sv
// Control/status bundle between a run supervisor (master) and the hart run
// controller (slave).
//   start, abort   : 1-cycle command pulses from the supervisor
//   hart_halted    : per-hart halt level coming from the hart array
//   hart_reset     : per-hart active-high reset driven by the controller
//   running        : controller is releasing or running harts
//   done, timeout  : sticky completion flags
//   halted_mask    : sticky per-hart halt record
//   cycle_count    : saturating count of release+run cycles
interface hart_run_ctrl_if #(
    parameter int NUM_HARTS = 1,
    parameter int CNT_W     = 32
);

    logic                 start;
    logic                 abort;
    logic [NUM_HARTS-1:0] hart_halted;
    logic [NUM_HARTS-1:0] hart_reset;
    logic                 running;
    logic                 done;
    logic                 timeout;
    logic [NUM_HARTS-1:0] halted_mask;
    logic [CNT_W-1:0]     cycle_count;

    modport master (
        output start, abort, hart_halted,
        input  hart_reset, running, done, timeout, halted_mask, cycle_count
    );

    modport slave (
        input  start, abort, hart_halted,
        output hart_reset, running, done, timeout, halted_mask, cycle_count
    );

endinterface

// File: rtl/hart_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears count
//   clear : synchronous clear, has priority over en
//   en    : count up by one, holding at all ones
//   count : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hart_run_ctrl.sv
// Run controller for an array of harts: holds all hart resets after a start
// command, releases them (optionally staggered), records per-hart halts and
// ends the run on all-halted (DONE) or on an exhausted cycle budget (TMO).
//   clk   : clock, rising edge
//   reset : asynchronous active-low controller reset
//   bus   : slave side of hart_run_ctrl_if (commands in, hart resets and
//           status out); all outputs are registered
module hart_run_ctrl
    import hart_ctrl_pkg::*;
#(
    parameter int NUM_HARTS      = 1,
    parameter int RESET_CYCLES   = 4,
    parameter int STAGGER_CYCLES = 0,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input logic            clk,
    input logic            reset,
    hart_run_ctrl_if.slave bus
);

    localparam int PH_W     = 32;
    localparam int LAST_REL = (NUM_HARTS - 1) * STAGGER_CYCLES;
    // With a single hart or no stagger there is nothing to sequence, so HOLD
    // goes straight to RUN with every reset dropping together.
    localparam bit DIRECT_RUN = (STAGGER_CYCLES == 0) || (NUM_HARTS == 1);
    localparam logic [NUM_HARTS-1:0] ALL_ONES = {NUM_HARTS{1'b1}};

    hart_ctrl_state_t     state_q, state_next;
    logic [NUM_HARTS-1:0] hart_reset_q, hart_reset_next;
    logic [NUM_HARTS-1:0] halted_mask_q, halted_mask_next;
    logic [NUM_HARTS-1:0] halted_upd;
    logic [NUM_HARTS-1:0] rel_mask;
    logic                 running_q, done_q, timeout_q;
    logic [PH_W-1:0]      phase, rel_idx;
    logic [CNT_W-1:0]     cycle_count;
    logic                 in_run, all_halted, budget_hit, phase_clr, cyc_clr;

    // Phase counter: cycles spent in the current HOLD or RELEASE visit.
    sat_counter #(.W(PH_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .clear (phase_clr),
        .en    (1'b1),
        .count (phase)
    );

    // Run-cycle counter: frozen outside RELEASE/RUN, cleared by start/abort.
    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clear (cyc_clr),
        .en    (in_run),
        .count (cycle_count)
    );

    always_comb begin
        in_run     = (state_q == ST_RELEASE) || (state_q == ST_RUN);
        // A halt only counts once the hart is actually out of reset.
        halted_upd = halted_mask_q | (bus.hart_halted & ~hart_reset_q);
        all_halted = (halted_upd == ALL_ONES);
        budget_hit = (TIMEOUT_CYCLES != 0) &&
                     (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
        // Release index of the cycle being prepared: 0 on RELEASE entry,
        // phase+1 while staying in RELEASE.
        rel_idx = (state_q == ST_RELEASE) ? phase + PH_W'(1) : '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            rel_mask[i] = (PH_W'(i * STAGGER_CYCLES) > rel_idx);
        end
    end

    always_comb begin
        state_next = state_q;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else if (bus.start) begin
            state_next = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (phase == PH_W'(RESET_CYCLES - 1)) begin
                        state_next = DIRECT_RUN ? ST_RUN : ST_RELEASE;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    // All-halted is checked first so it wins a tie with
                    // budget expiry.
                    if (all_halted) begin
                        state_next = ST_DONE;
                    end else if (budget_hit) begin
                        state_next = ST_TMO;
                    end else if ((state_q == ST_RELEASE) &&
                                 (rel_idx >= PH_W'(LAST_REL))) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = state_q;
            endcase
        end

        phase_clr = (state_next != state_q) || (bus.start && !bus.abort);
        cyc_clr   = bus.start || bus.abort;

        case (state_next)
            ST_RELEASE: hart_reset_next = rel_mask;
            ST_RUN:     hart_reset_next = '0;
            default:    hart_reset_next = ALL_ONES;
        endcase

        halted_mask_next = halted_mask_q;
        if (bus.abort || bus.start) begin
            halted_mask_next = '0;
        end else if (in_run) begin
            halted_mask_next = halted_upd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            hart_reset_q  <= ALL_ONES;
            halted_mask_q <= '0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_next;
            hart_reset_q  <= hart_reset_next;
            halted_mask_q <= halted_mask_next;
            running_q     <= (state_next == ST_RELEASE) || (state_next == ST_RUN);
            done_q        <= (state_next == ST_DONE);
            timeout_q     <= (state_next == ST_TMO);
        end
    end

    assign bus.hart_reset  = hart_reset_q;
    assign bus.halted_mask = halted_mask_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_hart_run_ctrl.sv
// Bench for hart_run_ctrl: one single-hart instance and one 4-hart staggered
// instance with a short budget, checked against a timing model derived from
// release times and halt times.
module tb_hart_run_ctrl;

    localparam int RC = 4;
    localparam int S4 = 3;
    localparam int T4 = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hart_run_ctrl_if #(.NUM_HARTS(1), .CNT_W(32)) bus1 ();
    hart_run_ctrl_if #(.NUM_HARTS(4), .CNT_W(32)) bus4 ();

    hart_run_ctrl #(.NUM_HARTS(1), .RESET_CYCLES(RC), .STAGGER_CYCLES(0),
                    .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    hart_run_ctrl #(.NUM_HARTS(4), .RESET_CYCLES(RC), .STAGGER_CYCLES(S4),
                    .TIMEOUT_CYCLES(T4), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.hart_halted = '0;
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.hart_halted = '0;
        repeat (3) step();
        total++; if (bus1.hart_reset !== 1'b1) begin bad++; $display("FAIL rst_hart_reset1: got %0h expected 1", bus1.hart_reset); end
        total++; if (bus4.hart_reset !== 4'hF) begin bad++; $display("FAIL rst_hart_reset4: got %0h expected f", bus4.hart_reset); end
        total++; if ({bus1.done, bus1.timeout, bus1.running} !== 3'b000) begin bad++; $display("FAIL rst_flags1: got %b expected 000", {bus1.done, bus1.timeout, bus1.running}); end
        total++; if ({bus4.done, bus4.timeout, bus4.running} !== 3'b000) begin bad++; $display("FAIL rst_flags4: got %b expected 000", {bus4.done, bus4.timeout, bus4.running}); end
        total++; if (bus4.cycle_count !== 32'd0) begin bad++; $display("FAIL rst_count: got %0d expected 0", bus4.cycle_count); end
        total++; if (bus4.halted_mask !== 4'h0) begin bad++; $display("FAIL rst_mask: got %0h expected 0", bus4.halted_mask); end
        #3 reset = 1'b1;
        step();
    endtask

    task automatic test_single_halt();
        int s;
        bus1.hart_halted = '0;
        s = cyc;
        bus1.start = 1'b1; step(); bus1.start = 1'b0;
        wait_cycle(s + RC);
        total++; if (bus1.hart_reset !== 1'b1) begin bad++; $display("FAIL t2_still_held: got %0h expected 1", bus1.hart_reset); end
        step();
        total++; if (bus1.hart_reset !== 1'b0) begin bad++; $display("FAIL t2_released: got %0h expected 0", bus1.hart_reset); end
        total++; if (bus1.running !== 1'b1) begin bad++; $display("FAIL t2_running: got %0b expected 1", bus1.running); end
        wait_cycle(s + 30);
        bus1.hart_halted = 1'b1;
        step();
        total++; if (bus1.done !== 1'b1) begin bad++; $display("FAIL t2_done: got %0b expected 1", bus1.done); end
        total++; if (bus1.hart_reset !== 1'b1) begin bad++; $display("FAIL t2_freeze: got %0h expected 1", bus1.hart_reset); end
        total++; if (bus1.cycle_count !== 32'd26) begin bad++; $display("FAIL t2_count: got %0d expected 26", bus1.cycle_count); end
        total++; if ({bus1.timeout, bus1.running} !== 2'b00) begin bad++; $display("FAIL t2_flags: got %b expected 00", {bus1.timeout, bus1.running}); end
        step();
        total++; if (bus1.cycle_count !== 32'd26) begin bad++; $display("FAIL t2_frozen: got %0d expected 26", bus1.cycle_count); end
    endtask

    task automatic test_restart_from_done();
        int s;
        bus1.hart_halted = 1'b0;
        s = cyc;
        bus1.start = 1'b1; step(); bus1.start = 1'b0;
        total++; if ({bus1.done, bus1.halted_mask, bus1.running} !== 3'b000) begin bad++; $display("FAIL t6_restart_flags: got %b expected 000", {bus1.done, bus1.halted_mask, bus1.running}); end
        total++; if (bus1.cycle_count !== 32'd0) begin bad++; $display("FAIL t6_restart_count: got %0d expected 0", bus1.cycle_count); end
        wait_cycle(s + RC + 1);
        total++; if (bus1.hart_reset !== 1'b0) begin bad++; $display("FAIL t6_restart_release: got %0h expected 0", bus1.hart_reset); end
    endtask

    task automatic test_abort();
        step();
        total++; if (bus1.running !== 1'b1) begin bad++; $display("FAIL t6_pre_abort: got %0b expected 1", bus1.running); end
        bus1.abort = 1'b1; step(); bus1.abort = 1'b0;
        total++; if ({bus1.hart_reset, bus1.running, bus1.done, bus1.timeout, bus1.halted_mask} !== 5'b10000) begin bad++; $display("FAIL t6_abort: got %b expected 10000", {bus1.hart_reset, bus1.running, bus1.done, bus1.timeout, bus1.halted_mask}); end
        // start and abort together from IDLE
        bus1.start = 1'b1; bus1.abort = 1'b1; step(); bus1.start = 1'b0; bus1.abort = 1'b0;
        repeat (RC + 2) step();
        total++; if ({bus1.hart_reset, bus1.running} !== 2'b10) begin bad++; $display("FAIL t6_both_idle: got %b expected 10", {bus1.hart_reset, bus1.running}); end
        // start and abort together while running
        bus1.start = 1'b1; step(); bus1.start = 1'b0;
        repeat (RC + 1) step();
        bus1.start = 1'b1; bus1.abort = 1'b1; step(); bus1.start = 1'b0; bus1.abort = 1'b0;
        repeat (RC + 2) step();
        total++; if ({bus1.hart_reset, bus1.running} !== 2'b10) begin bad++; $display("FAIL t6_both_run: got %b expected 10", {bus1.hart_reset, bus1.running}); end
    endtask

    task automatic test_stagger();
        int s, r;
        logic [3:0] exp_rst;
        bus4.hart_halted = '0;
        s = cyc;
        bus4.start = 1'b1; step(); bus4.start = 1'b0;
        r = s + 1 + RC;
        while (cyc <= r + 10) begin
            for (int i = 0; i < 4; i++) exp_rst[i] = (cyc < r + S4 * i);
            total++; if (bus4.hart_reset !== exp_rst) begin bad++; $display("FAIL t3_release@%0d: got %0h expected %0h", cyc - r, bus4.hart_reset, exp_rst); end
            bus4.hart_halted[3] = (cyc == r + 7);
            step();
        end
        total++; if (bus4.halted_mask[3] !== 1'b0) begin bad++; $display("FAIL t3_ignored_halt: got %0b expected 0", bus4.halted_mask[3]); end
        bus4.hart_halted = '0;
        bus4.abort = 1'b1; step(); bus4.abort = 1'b0;
        total++; if ({bus4.hart_reset, bus4.running, bus4.done, bus4.timeout} !== 7'b1111000) begin bad++; $display("FAIL t3_abort: got %b expected 1111000", {bus4.hart_reset, bus4.running, bus4.done, bus4.timeout}); end
    endtask

    // Model: hart i leaves reset at R+i*S4 and is recorded in the first cycle it
    // is both out of reset and halted; the run ends one cycle after the last
    // record, or at R+T4 if that comes first (all-halted wins a tie).
    task automatic run_model(input int hoff[4], input string tag);
        int s, r, last, endc, c, lim, exp_cnt;
        int rel[4];
        int rec[4];
        bit is_done;
        logic [3:0] exp_rst, exp_mask;
        logic [2:0] exp_flags;
        bus4.hart_halted = '0;
        s = cyc;
        bus4.start = 1'b1; step(); bus4.start = 1'b0;
        r = s + 1 + RC;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            rel[i] = r + S4 * i;
            rec[i] = (r + hoff[i] > rel[i]) ? r + hoff[i] : rel[i];
            if (rec[i] > last) last = rec[i];
        end
        is_done = (last + 1 <= r + T4);
        endc = is_done ? last + 1 : r + T4;
        for (int k = 0; k < 200 && cyc <= endc + 2; k++) begin
            c = cyc;
            lim = (c < endc) ? c : endc;
            for (int i = 0; i < 4; i++) begin
                exp_rst[i]  = !(c >= rel[i] && c < endc);
                exp_mask[i] = (rec[i] + 1 <= lim);
                bus4.hart_halted[i] = (c >= r + hoff[i]);
            end
            exp_cnt   = (c < r) ? 0 : lim - r;
            exp_flags = {(c >= r && c < endc), (is_done && c >= endc), (!is_done && c >= endc)};
            total++; if (bus4.hart_reset !== exp_rst) begin bad++; $display("FAIL %s_hart_reset@%0d: got %0h expected %0h", tag, c - s, bus4.hart_reset, exp_rst); end
            total++; if ({bus4.running, bus4.done, bus4.timeout} !== exp_flags) begin bad++; $display("FAIL %s_flags@%0d: got %b expected %b", tag, c - s, {bus4.running, bus4.done, bus4.timeout}, exp_flags); end
            total++; if (bus4.cycle_count !== 32'(exp_cnt)) begin bad++; $display("FAIL %s_count@%0d: got %0d expected %0d", tag, c - s, bus4.cycle_count, exp_cnt); end
            total++; if (bus4.halted_mask !== exp_mask) begin bad++; $display("FAIL %s_mask@%0d: got %0h expected %0h", tag, c - s, bus4.halted_mask, exp_mask); end
            step();
        end
        total++; if (cyc <= endc + 2) begin bad++; $display("FAIL %s_budget: got cycle %0d expected past %0d", tag, cyc, endc + 2); end
    endtask

    task automatic test_timeout();
        int h[4];
        h = '{1000, 1000, 1000, 1000};
        run_model(h, "t4");
        total++; if ({bus4.timeout, bus4.done} !== 2'b10) begin bad++; $display("FAIL t4_timeout: got %b expected 10", {bus4.timeout, bus4.done}); end
        total++; if (bus4.cycle_count !== 32'd20) begin bad++; $display("FAIL t4_count: got %0d expected 20", bus4.cycle_count); end
    endtask

    task automatic test_same_cycle();
        int h[4];
        h = '{0, 1, 2, 19};
        run_model(h, "t5");
        total++; if ({bus4.done, bus4.timeout} !== 2'b10) begin bad++; $display("FAIL t5_done_wins: got %b expected 10", {bus4.done, bus4.timeout}); end
        total++; if (bus4.cycle_count !== 32'd20) begin bad++; $display("FAIL t5_count: got %0d expected 20", bus4.cycle_count); end
    endtask

    task automatic test_random();
        int h[4];
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) h[i] = int'($urandom_range(0, 26)) - 4;
            run_model(h, "rnd");
        end
    endtask

    task automatic test_async_reset();
        int s;
        s = cyc;
        bus1.start = 1'b1; step(); bus1.start = 1'b0;
        wait_cycle(s + RC + 3);
        total++; if (bus1.hart_reset !== 1'b0) begin bad++; $display("FAIL t1_pre_async: got %0h expected 0", bus1.hart_reset); end
        #2 reset = 1'b0;
        #1;
        total++; if ({bus1.hart_reset, bus1.running} !== 2'b10) begin bad++; $display("FAIL t1_async: got %b expected 10", {bus1.hart_reset, bus1.running}); end
        total++; if (bus1.cycle_count !== 32'd0) begin bad++; $display("FAIL t1_async_count: got %0d expected 0", bus1.cycle_count); end
        #1 reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_halt();
        test_restart_from_done();
        test_abort();
        test_stagger();
        test_timeout();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
